// File: rtl/icache.sv
// Direct-mapped, read-only instruction cache with 32-byte lines and hit/miss counters.
// Tag, data and valid bits are held in flops; only valid bits and counters are reset.
module icache #(
  parameter int unsigned S_INDEX = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [31:0]  mem_address,
  input  logic         mem_read,
  output logic [31:0]  mem_rdata,
  output logic         mem_resp,
  output logic [31:0]  pmem_address,
  output logic         pmem_read,
  input  logic [255:0] pmem_rdata,
  input  logic         pmem_resp,
  output logic [31:0]  hit_count,
  output logic [31:0]  miss_count
);

  localparam int unsigned SETS  = 1 << S_INDEX;
  localparam int unsigned TAG_W = 27 - S_INDEX;

  typedef enum logic [1:0] {
    IDLE,
    COMPARE,
    FETCH
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         req_addr_q, req_addr_d;
  logic [31:0]         hit_q, hit_d;
  logic [31:0]         miss_q, miss_d;
  logic [SETS-1:0]     valid_q;
  logic [TAG_W-1:0]    tag_q  [SETS];
  logic [255:0]        data_q [SETS];

  logic [S_INDEX-1:0]  idx;
  logic [TAG_W-1:0]    req_tag;
  logic [2:0]          word_sel;
  logic                hit;
  logic                fill;
  logic                unused_byte_ofs;

  assign idx      = req_addr_q[4+S_INDEX:5];
  assign req_tag  = req_addr_q[31:5+S_INDEX];
  assign word_sel = req_addr_q[4:2];
  assign hit      = valid_q[idx] && (tag_q[idx] == req_tag);

  // Instruction fetch is word-aligned; the byte offset is latched but never used.
  assign unused_byte_ofs = ^req_addr_q[1:0];

  assign hit_count  = hit_q;
  assign miss_count = miss_q;

  always_comb begin
    state_d      = state_q;
    req_addr_d   = req_addr_q;
    hit_d        = hit_q;
    miss_d       = miss_q;
    mem_resp     = 1'b0;
    mem_rdata    = '0;
    pmem_read    = 1'b0;
    pmem_address = '0;
    fill         = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read) begin
          req_addr_d = mem_address;
          state_d    = COMPARE;
        end
      end
      COMPARE: begin
        if (!mem_read) begin
          state_d = IDLE;
        end else if (hit) begin
          mem_resp  = 1'b1;
          mem_rdata = data_q[idx][{word_sel, 5'b0} +: 32];
          hit_d     = hit_q + 32'd1;
          state_d   = IDLE;
        end else begin
          miss_d  = miss_q + 32'd1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        pmem_read    = 1'b1;
        pmem_address = {req_tag, idx, 5'b0};
        if (pmem_resp) begin
          fill    = 1'b1;
          state_d = COMPARE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= '0;
      hit_q      <= '0;
      miss_q     <= '0;
      valid_q    <= '0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      hit_q      <= hit_d;
      miss_q     <= miss_d;
      if (fill) begin
        valid_q[idx] <= 1'b1;
      end
    end
  end

  // Line storage has no reset; a reset-coincident fill is dropped so nothing lands.
  always_ff @(posedge clk) begin
    if (fill && !rst) begin
      tag_q[idx]  <= req_tag;
      data_q[idx] <= pmem_rdata;
    end
  end

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: expected words queued per request, popped on mem_resp.
module tb_icache;

  logic         clk;
  logic         rst;
  logic [31:0]  mem_address;
  logic         mem_read;
  logic [31:0]  mem_rdata;
  logic         mem_resp;
  logic [31:0]  pmem_address;
  logic         pmem_read;
  logic [255:0] pmem_rdata;
  logic         pmem_resp;
  logic [31:0]  hit_count;
  logic [31:0]  miss_count;

  icache #(.S_INDEX(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .mem_address  (mem_address),
    .mem_read     (mem_read),
    .mem_rdata    (mem_rdata),
    .mem_resp     (mem_resp),
    .pmem_address (pmem_address),
    .pmem_read    (pmem_read),
    .pmem_rdata   (pmem_rdata),
    .pmem_resp    (pmem_resp),
    .hit_count    (hit_count),
    .miss_count   (miss_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned vectors     = 0;
  int unsigned miscompares = 0;
  logic [31:0] exp_q[$];
  logic [31:0] salt        = '0;
  logic [31:0] cur_addr    = '0;
  int unsigned resp_lat    = 1;
  bit          auto_resp   = 1'b1;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memw(input logic [31:0] line, input int unsigned w,
                                       input logic [31:0] s);
    if (line == 32'h40 && w == 2 && s == 32'h0) return 32'hDEAD_BEEF;
    return (line * 32'h9E37_79B1) ^ (w * 32'h0101_0101) ^ s ^ 32'h0F0F_1234;
  endfunction

  function automatic logic [255:0] mem_line(input logic [31:0] line, input logic [31:0] s);
    logic [255:0] l;
    for (int unsigned w = 0; w < 8; w++) l[w*32 +: 32] = memw(line, w, s);
    return l;
  endfunction

  // Response scoreboard plus idle-output check.
  always @(negedge clk) begin
    if (!rst) begin
      if (exp_q.size() == 0) check_eq("spurious_resp", {31'b0, mem_resp}, 32'd0);
      else if (mem_resp) check_eq("rdata", mem_rdata, exp_q.pop_front());
      if (!mem_resp) check_eq("rdata_idle", mem_rdata, 32'd0);
    end
  end

  // Line memory: answers each fetch resp_lat cycles after pmem_read is seen.
  initial begin
    pmem_resp  = 1'b0;
    pmem_rdata = '0;
    forever begin
      @(negedge clk);
      if (auto_resp && pmem_read && !rst) begin
        check_eq("pmem_address", pmem_address, {cur_addr[31:5], 5'b0});
        repeat (resp_lat - 1) @(posedge clk);
        #1;
        pmem_rdata = mem_line(pmem_address, salt);
        pmem_resp  = 1'b1;
        @(posedge clk);
        #1;
        pmem_resp = 1'b0;
        check_eq("pmem_read_drop", {31'b0, pmem_read}, 32'd0);
      end
    end
  end

  task automatic do_reset();
    rst       = 1'b1;
    mem_read  = 1'b0;
    pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_hit_count", hit_count, 32'd0);
    check_eq("rst_miss_count", miss_count, 32'd0);
    check_eq("rst_pmem_read", {31'b0, pmem_read}, 32'd0);
    check_eq("rst_pmem_address", pmem_address, 32'd0);
    check_eq("rst_mem_resp", {31'b0, mem_resp}, 32'd0);
    rst = 1'b0;
  endtask

  // Leaves mem_read high so a following call forms a back-to-back request.
  task automatic do_read(input logic [31:0] a, input int exp_lat);
    int n;
    bit got;
    exp_q.push_back(memw({a[31:5], 5'b0}, 32'(a[4:2]), salt));
    cur_addr    = a;
    mem_address = a;
    mem_read    = 1'b1;
    n   = 0;
    got = 1'b0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (mem_resp) got = 1'b1;
    end
    if (!got) check_eq("resp_timeout", {31'b0, mem_resp}, 32'd1);
    else if (exp_lat >= 0) check_eq("latency", n - 1, exp_lat);
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    mem_read = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    rst         = 1'b1;
    mem_read    = 1'b0;
    mem_address = '0;
    @(posedge clk);
    #1;

    // Cold miss then back-to-back hit in the same line.
    do_reset();
    salt     = 32'h0;
    resp_lat = 5;
    do_read(32'h0000_0040, 7);
    check_eq("cold_miss_count", miss_count, 32'd1);
    do_read(32'h0000_0048, 1);
    go_idle();
    check_eq("cold_miss_count2", miss_count, 32'd1);
    check_eq("cold_hit_count", hit_count, 32'd2);

    // Conflict on index 8: each fill must replace the previous line.
    do_reset();
    resp_lat = 2;
    salt = 32'h1111_0001; do_read(32'h0000_0100, 4);
    salt = 32'h2222_0002; do_read(32'h0000_0300, 4);
    salt = 32'h3333_0003; do_read(32'h0000_0100, 4);
    go_idle();
    check_eq("conflict_miss_count", miss_count, 32'd3);
    check_eq("conflict_hit_count", hit_count, 32'd3);

    // Reset during FETCH, with pmem_resp both coincident with and after the reset edge.
    do_reset();
    auto_resp   = 1'b0;
    salt        = 32'h4444_0004;
    mem_address = 32'h0000_0020;
    mem_read    = 1'b1;
    n = 0;
    while (!pmem_read && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_eq("fetch_start", {31'b0, pmem_read}, 32'd1);
    check_eq("midfetch_miss_count", miss_count, 32'd1);
    @(posedge clk);
    #1;
    rst        = 1'b1;
    mem_read   = 1'b0;
    pmem_rdata = mem_line(32'h0000_0020, salt);
    pmem_resp  = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("midfetch_pmem_read", {31'b0, pmem_read}, 32'd0);
    check_eq("midfetch_miss_zero", miss_count, 32'd0);
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("midfetch_hit_zero", hit_count, 32'd0);
    auto_resp = 1'b1;
    resp_lat  = 3;
    do_read(32'h0000_0020, 5);
    go_idle();
    check_eq("refetch_miss_count", miss_count, 32'd1);
    check_eq("refetch_hit_count", hit_count, 32'd1);

    // Request withdrawn after a single cycle on a valid line.
    mem_address = 32'h0000_0024;
    mem_read    = 1'b1;
    @(posedge clk);
    #1;
    mem_read = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("withdraw_hit_count", hit_count, 32'd1);
    check_eq("withdraw_miss_count", miss_count, 32'd1);

    // Stray pmem_resp while IDLE must be ignored.
    pmem_rdata = '1;
    pmem_resp  = 1'b1;
    @(posedge clk);
    #1;
    pmem_resp = 1'b0;
    @(posedge clk);
    #1;
    check_eq("stray_pmem_read", {31'b0, pmem_read}, 32'd0);
    check_eq("stray_miss_count", miss_count, 32'd1);
    do_read(32'h0000_0060, 5);
    do_read(32'h0000_0064, 1);
    do_read(32'h0000_0024, 1);
    go_idle();
    check_eq("stray_miss_count2", miss_count, 32'd2);
    check_eq("stray_hit_count", hit_count, 32'd4);

    // Sweep all words of 16 lines, two passes, random memory latency.
    do_reset();
    salt = 32'h5A5A_0005;
    for (int unsigned p = 0; p < 2; p++) begin
      for (int unsigned i = 0; i < 16; i++) begin
        for (int unsigned w = 0; w < 8; w++) begin
          resp_lat = $urandom_range(1, 4);
          do_read(32'h0000_1000 + i * 32 + w * 4, -1);
        end
      end
    end
    go_idle();
    check_eq("sweep_miss_count", miss_count, 32'd16);
    check_eq("sweep_hit_count", hit_count, 32'd256);

    repeat (2) @(posedge clk);
    check_eq("scoreboard_drained", exp_q.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation time limit exceeded");
  end

endmodule

// File: doc/icache.md
# icache

Direct-mapped, read-only instruction cache between the pipelined core's instruction-memory port (imem_address/imem_read/imem_rdata/imem_resp) and a 256-bit line-granular physical memory port. Hits return a 32-bit word; misses fetch a full 32-byte line, install it, then answer the pending request. Hit and miss event counters are included for performance bring-up.

## Interface
- S_INDEX, 4, index bits; 2^S_INDEX sets of one 32-byte line each; tag width = 27 - S_INDEX
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- mem_address  in  32  byte address from core; [1:0] ignored, [4:2] word select, [4+S_INDEX:5] index, [31:5+S_INDEX] tag
- mem_read  in  1  request; held high with stable address until mem_resp
- mem_rdata  out  32  instruction word, valid only while mem_resp=1
- mem_resp  out  1  one-cycle response pulse
- pmem_address  out  32  line address {tag,index,5'b0}
- pmem_read  out  1  line fetch request, held until pmem_resp
- pmem_rdata  in  256  fetched line, word w at bits [32w+31:32w]
- pmem_resp  in  1  one-cycle line-valid pulse
- hit_count  out  32  number of hit responses, wraps at 2^32
- miss_count  out  32  number of line fetches started, wraps at 2^32

## Operation
- Storage: valid[2^S_INDEX], tag[2^S_INDEX], data[2^S_INDEX] x 256 bits, all flops. Only valid bits and counters are reset; tag/data contents undefined after reset.
- FSM states IDLE, COMPARE, FETCH.
- IDLE: mem_resp=0, pmem_read=0. If mem_read=1: latch mem_address into req_addr, go COMPARE.
- COMPARE: hit = valid[idx] && tag[idx]==req tag.
  - mem_read=0 (request withdrawn): no response, no counter change, go IDLE.
  - hit: mem_resp=1, mem_rdata = data[idx] word req_addr[4:2], hit_count+1, go IDLE.
  - miss: miss_count+1, go FETCH.
- FETCH: pmem_read=1, pmem_address={req tag, idx, 5'b0}. Stay until pmem_resp=1; then data[idx]<=pmem_rdata, tag[idx]<=req tag, valid[idx]<=1, go COMPARE (guaranteed hit, counted as hit). Fill completes even if mem_read drops during FETCH.
- Eviction: fill overwrites the indexed line unconditionally (read-only, no writeback).
- Outputs are a function of state and registered req_addr only; mem_address changes after IDLE are ignored until next IDLE.
- pmem_resp outside FETCH is ignored.

## Timing
- Reset: state=IDLE, all valid=0, hit_count=0, miss_count=0, mem_resp=0, pmem_read=0, pmem_address=0, mem_rdata=0 when not responding.
- Hit latency: mem_read seen in IDLE at edge N -> mem_resp high during cycle N+1. Back-to-back hits: one response every 2 cycles.
- Miss latency: request at edge N, COMPARE cycle N+1, pmem_read high from cycle N+2 until the pmem_resp cycle M, COMPARE/mem_resp in cycle M+1. Total = memory latency + 2 cycles after request.
- pmem_read deasserts the cycle after pmem_resp.
- rst during FETCH: next cycle state=IDLE, pmem_read=0, no install, valid cleared, counters zeroed; a pmem_resp arriving at/after the reset edge is ignored.
- Simultaneous rst and pmem_resp: reset wins.
- Counter wrap: 32'hFFFF_FFFF + 1 -> 0.

## Test plan
- Cold miss: reset, read 0x0000_0040, memory returns line with word2 = 0xDEAD_BEEF after 5 cycles, read 0x0000_0048 -> first request: pmem_address=0x0000_0040, one fetch, mem_rdata=line word0; second read hits 2 cycles later with 0xDEAD_BEEF, miss_count=1, hit_count=2.
- Conflict (S_INDEX=4): read 0x0000_0100 then 0x0000_0300 (same index 8, different tag) then 0x0000_0100 -> three fetches, miss_count=3, data always from the most recent fill.
- Reset mid-fetch: miss on 0x0000_0020, assert rst for 1 cycle while pmem_read=1, then drive pmem_resp -> pmem_read low after reset, no mem_resp, line not valid; re-read 0x0000_0020 triggers new fetch.
- Withdrawn request: assert mem_read one cycle only on a valid line -> no mem_resp, hit_count unchanged.
- Stray pmem_resp in IDLE with pmem_rdata=all ones -> no state change, subsequent miss fetches normally.
- Sweep: read every word of 16 distinct lines twice -> miss_count=16, hit_count=16*8*2, every returned word matches memory model.
